// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit registered multiplexer with manual select
// and an auto-scan mode that dwells DWELL cycles per channel and wraps.
module scan_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int DWELL = 4,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   din,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        dout,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    valid,
    output logic                    wrap,
    output logic                    err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [WIDTH-1:0]   dout_nxt;
    logic [WIDTH-1:0]   pick;
    logic               valid_nxt;
    logic               wrap_nxt;
    logic               err_nxt;
    logic               sel_legal;

    // A manual select is legal only when it names an existing channel.
    always_comb begin
        sel_legal = (32'(sel) < N_CH);
    end

    // Next-state, channel pointer, dwell counter and status flags.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = cur_sel;
        valid_nxt = valid;
        err_nxt   = err;
        wrap_nxt  = 1'b0;
        if (en) begin
            if (!mode) begin
                state_nxt = MAN;
                cnt_nxt   = '0;
                if (sel_legal) begin
                    sel_nxt   = sel;
                    valid_nxt = 1'b1;
                    err_nxt   = 1'b0;
                end else begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b1;
                end
            end else begin
                state_nxt = SCAN;
                valid_nxt = 1'b1;
                err_nxt   = 1'b0;
                if (state != SCAN) begin
                    cnt_nxt = '0;
                end else if (32'(cnt) == DWELL - 1) begin
                    cnt_nxt = '0;
                    if (32'(cur_sel) == N_CH - 1) begin
                        sel_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        sel_nxt = cur_sel + SEL_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end
    end

    // Word of the channel that cur_sel will point at after this edge.
    always_comb begin
        pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (32'(sel_nxt) == k) begin
                pick = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output data: held when frozen, zeroed on an illegal manual select.
    always_comb begin
        dout_nxt = dout;
        if (en) begin
            if (!mode && !sel_legal) begin
                dout_nxt = '0;
            end else begin
                dout_nxt = pick;
            end
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_sel <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_sel <= sel_nxt;
            dout    <= dout_nxt;
            valid   <= valid_nxt;
            wrap    <= wrap_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed and randomized checks of scan_mux against a
// position-based behavioural model (N_CH=5, WIDTH=8, DWELL=3).
module tb_scan_mux;

    localparam int N_CH  = 5;
    localparam int WIDTH = 8;
    localparam int DWELL = 3;
    localparam int SEL_W = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH*WIDTH-1:0]  din;
    logic                   en;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [WIDTH-1:0]       dout;
    logic [SEL_W-1:0]       cur_sel;
    logic                   valid;
    logic                   wrap;
    logic                   err;

    int compared   = 0;
    int mismatched = 0;

    // Model: scan position counts enabled scan cycles since scan entry.
    logic [WIDTH-1:0] m_dout;
    int               m_cur;
    bit               m_valid;
    bit               m_wrap;
    bit               m_err;
    bit               m_in_scan;
    int               m_start;
    int               m_pos;

    logic [7:0] sweep_exp [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    scan_mux #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH),
        .DWELL (DWELL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .en      (en),
        .mode    (mode),
        .sel     (sel),
        .dout    (dout),
        .cur_sel (cur_sel),
        .valid   (valid),
        .wrap    (wrap),
        .err     (err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] chanOf(input int k);
        return din[k*WIDTH +: WIDTH];
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        m_dout    = '0;
        m_cur     = 0;
        m_valid   = 1'b0;
        m_wrap    = 1'b0;
        m_err     = 1'b0;
        m_in_scan = 1'b0;
        m_start   = 0;
        m_pos     = 0;
    endtask

    task automatic modelStep();
        int ch;
        if (!en) begin
            m_wrap = 1'b0;
            return;
        end
        if (!mode) begin
            m_in_scan = 1'b0;
            m_wrap    = 1'b0;
            if (int'(sel) < N_CH) begin
                m_cur   = int'(sel);
                m_dout  = chanOf(m_cur);
                m_valid = 1'b1;
                m_err   = 1'b0;
            end else begin
                m_dout  = '0;
                m_valid = 1'b0;
                m_err   = 1'b1;
            end
        end else begin
            if (!m_in_scan) begin
                m_in_scan = 1'b1;
                m_start   = m_cur;
                m_pos     = 0;
            end else begin
                m_pos++;
            end
            ch      = (m_start + m_pos / DWELL) % N_CH;
            m_wrap  = (m_pos > 0) && (m_pos % DWELL == 0) && (ch == 0);
            m_cur   = ch;
            m_dout  = chanOf(ch);
            m_valid = 1'b1;
            m_err   = 1'b0;
        end
    endtask

    task automatic checkOutput();
        compareField("dout",    32'(dout),    32'(m_dout));
        compareField("cur_sel", 32'(cur_sel), 32'(m_cur));
        compareField("valid",   32'(valid),   32'(m_valid));
        compareField("wrap",    32'(wrap),    32'(m_wrap));
        compareField("err",     32'(err),     32'(m_err));
    endtask

    task automatic applyStimulus(input logic e, input logic m, input int s);
        en   = e;
        mode = m;
        sel  = SEL_W'(s);
    endtask

    // Advance to the falling edge, update the model for the rising edge
    // just taken, and compare every output against it.
    task automatic cycle();
        @(negedge clk);
        if (!rst_n) modelReset();
        else        modelStep();
        checkOutput();
    endtask

    task automatic assertResetNow();
        rst_n = 1'b0;
        #1;
        modelReset();
        compareField("async dout",    32'(dout),    32'h0);
        compareField("async cur_sel", 32'(cur_sel), 32'h0);
        compareField("async valid",   32'(valid),   32'h0);
        compareField("async wrap",    32'(wrap),    32'h0);
        compareField("async err",     32'(err),     32'h0);
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 0);
        din = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
        #2;
        assertResetNow();
        cycle();
        cycle();
        rst_n = 1'b1;

        // Manual sweep over channels 0..3.
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b0, s);
            cycle();
            compareField("sweep dout", 32'(dout), 32'(sweep_exp[s]));
            compareField("sweep valid", 32'(valid), 32'h1);
        end

        // Scan from channel 0 after a fresh reset.
        assertResetNow();
        cycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 0);
        for (int i = 0; i < N_CH * DWELL; i++) begin
            cycle();
            compareField("scan cur_sel", 32'(cur_sel), 32'(i / DWELL));
            compareField("scan wrap", 32'(wrap), 32'h0);
        end
        cycle();
        compareField("wrap cur_sel", 32'(cur_sel), 32'h0);
        compareField("wrap pulse", 32'(wrap), 32'h1);
        cycle();
        compareField("wrap drop", 32'(wrap), 32'h0);

        // Freeze mid-dwell on channel 0, then finish the dwell.
        applyStimulus(1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            compareField("freeze cur_sel", 32'(cur_sel), 32'h0);
            compareField("freeze dout", 32'(dout), 32'hA0);
        end
        applyStimulus(1'b1, 1'b1, 0);
        cycle();
        compareField("resume last dwell", 32'(cur_sel), 32'h0);
        cycle();
        compareField("resume advance", 32'(cur_sel), 32'h1);
        compareField("resume dout", 32'(dout), 32'hB1);

        // Illegal manual select, then the top legal channel.
        applyStimulus(1'b1, 1'b0, 6);
        cycle();
        compareField("illegal dout", 32'(dout), 32'h0);
        compareField("illegal valid", 32'(valid), 32'h0);
        compareField("illegal err", 32'(err), 32'h1);
        compareField("illegal cur_sel", 32'(cur_sel), 32'h1);
        applyStimulus(1'b1, 1'b0, 4);
        cycle();
        compareField("sel4 dout", 32'(dout), 32'hE4);
        compareField("sel4 err", 32'(err), 32'h0);

        // Manual channel 2, then scan starts there with a full dwell.
        applyStimulus(1'b1, 1'b0, 2);
        cycle();
        applyStimulus(1'b1, 1'b1, 0);
        for (int i = 0; i < DWELL; i++) begin
            cycle();
            compareField("switch hold", 32'(cur_sel), 32'h2);
        end
        cycle();
        compareField("switch next", 32'(cur_sel), 32'h3);
        compareField("switch dout", 32'(dout), 32'hD3);

        // Reset mid-dwell, then scan restarts at channel 0.
        assertResetNow();
        cycle();
        rst_n = 1'b1;
        cycle();
        compareField("restart cur_sel", 32'(cur_sel), 32'h0);
        compareField("restart dout", 32'(dout), 32'hA0);

        // Randomized operation with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom};
            din = r[N_CH*WIDTH-1:0];
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel = SEL_W'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
